// File: rtl/bus_rr.sv
// Shared-bus interconnect: NUM_M masters, NUM_S slaves, registered round-robin
// grant with optional hold limit, address decode with error flag, one-cycle read return.
module bus_rr #(
   parameter int NUM_M       = 2,
   parameter int NUM_S       = 2,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int REGION_BITS = 5,
   parameter int HOLD_MAX    = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_M-1:0]          m_req,
   input  logic [NUM_M-1:0]          m_wr,
   input  logic [NUM_M*ADDR_W-1:0]   m_address,
   input  logic [NUM_M*DATA_W-1:0]   m_dout,
   input  logic [NUM_S*DATA_W-1:0]   s_dout,
   output logic [NUM_M-1:0]          m_grant,
   output logic [DATA_W-1:0]         m_din,
   output logic                      m_err,
   output logic [NUM_S-1:0]          s_sel,
   output logic [ADDR_W-1:0]         s_address,
   output logic                      s_wr,
   output logic [DATA_W-1:0]         s_din
);

   localparam int OWN_W = $clog2(NUM_M);
   localparam int SEL_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam int K_W   = ADDR_W - REGION_BITS;
   localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

   logic [OWN_W-1:0] r_own;
   logic [NUM_M-1:0] r_grant;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             r_rd_pend;
   logic [SEL_W-1:0] r_rd_idx;

   logic [OWN_W-1:0] w_next;
   logic             w_other_req;
   logic             w_own_req;
   logic             w_own_wr;
   logic             w_change;
   logic [K_W-1:0]   w_k;
   logic             w_valid;
   logic             w_hit;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      s_address = '0;
      s_din     = '0;
      w_own_req = 1'b0;
      w_own_wr  = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         if (int'(r_own) == i) begin
            s_address = m_address[i*ADDR_W +: ADDR_W];
            s_din     = m_dout[i*DATA_W +: DATA_W];
            w_own_req = m_req[i];
            w_own_wr  = m_wr[i];
         end
      end
   end

   // Descending distance so the nearest requester after the owner is assigned last and wins.
   always_comb begin
      w_next      = r_own;
      w_other_req = 1'b0;
      for (int d = NUM_M - 1; d >= 1; d--) begin
         for (int i = 0; i < NUM_M; i++) begin
            if (m_req[i] && (i == (int'(r_own) + d) % NUM_M)) begin
               w_next      = OWN_W'(i);
               w_other_req = 1'b1;
            end
         end
      end
   end

   assign w_change = w_other_req &&
                     (!w_own_req || (HOLD_MAX != 0 && r_cnt == CNT_LAST));

   assign w_k     = s_address[ADDR_W-1:REGION_BITS];
   assign w_valid = int'(w_k) < NUM_S;
   assign w_hit   = w_own_req && w_valid;
   assign s_wr    = w_hit && w_own_wr;

   always_comb begin
      s_sel = '0;
      for (int k = 0; k < NUM_S; k++) begin
         s_sel[k] = w_hit && (int'(w_k) == k);
      end
   end

   always_comb begin
      m_din = '0;
      for (int k = 0; k < NUM_S; k++) begin
         if (r_rd_pend && int'(r_rd_idx) == k) begin
            m_din = s_dout[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      if (reset) begin
         r_own     <= '0;
         r_grant   <= NUM_M'(1);
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_rd_pend <= 1'b0;
         r_rd_idx  <= '0;
      end else begin
         if (w_change) begin
            r_own   <= w_next;
            r_grant <= NUM_M'(1) << w_next;
         end
         if (w_change || !w_own_req) begin
            r_cnt <= '0;
         end else if (HOLD_MAX != 0 && r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_err     <= w_own_req && !w_valid;
         r_rd_pend <= w_hit && !w_own_wr;
         r_rd_idx  <= SEL_W'(w_k);
      end
   end

   assign m_grant = r_grant;
   assign m_err   = r_err;

endmodule

// File: tb/tb_bus_rr.sv
// Directed scoreboard bench for bus_rr: three instances cover the 2-master default,
// a 3-master round-robin build and a HOLD_MAX=4 build.
module tb_bus_rr;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   string       tag_q[$];
   logic [63:0] val_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Instance a: NUM_M=2, NUM_S=2, HOLD_MAX=0
   logic [1:0]  a_req, a_wr, a_grant, a_sel;
   logic [15:0] a_addr;
   logic [63:0] a_mdout, a_sdout;
   logic [31:0] a_din, a_sdin;
   logic [7:0]  a_saddr;
   logic        a_err, a_swr;

   // Instance b: NUM_M=3, NUM_S=2, HOLD_MAX=0
   logic [2:0]  b_req, b_wr, b_grant;
   logic [1:0]  b_sel;
   logic [23:0] b_addr;
   logic [95:0] b_mdout;
   logic [63:0] b_sdout;
   logic [31:0] b_din, b_sdin;
   logic [7:0]  b_saddr;
   logic        b_err, b_swr;

   // Instance c: NUM_M=2, NUM_S=2, HOLD_MAX=4
   logic [1:0]  c_req, c_wr, c_grant, c_sel;
   logic [15:0] c_addr;
   logic [63:0] c_mdout, c_sdout;
   logic [31:0] c_din, c_sdin;
   logic [7:0]  c_saddr;
   logic        c_err, c_swr;

   logic [2:0] rr_req   [9] = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b111, 3'b110, 3'b111};
   logic [2:0] rr_grant [9] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
   logic [1:0] rr_sel   [9] = '{2'b01,  2'b00,  2'b10,  2'b00,  2'b01,  2'b00,  2'b01,  2'b00,  2'b10};

   bus_rr #(.NUM_M(2), .NUM_S(2), .ADDR_W(8), .DATA_W(32), .REGION_BITS(5), .HOLD_MAX(0)) u_a (
      .clk(clk), .reset(reset), .m_req(a_req), .m_wr(a_wr), .m_address(a_addr),
      .m_dout(a_mdout), .s_dout(a_sdout), .m_grant(a_grant), .m_din(a_din), .m_err(a_err),
      .s_sel(a_sel), .s_address(a_saddr), .s_wr(a_swr), .s_din(a_sdin));

   bus_rr #(.NUM_M(3), .NUM_S(2), .ADDR_W(8), .DATA_W(32), .REGION_BITS(5), .HOLD_MAX(0)) u_b (
      .clk(clk), .reset(reset), .m_req(b_req), .m_wr(b_wr), .m_address(b_addr),
      .m_dout(b_mdout), .s_dout(b_sdout), .m_grant(b_grant), .m_din(b_din), .m_err(b_err),
      .s_sel(b_sel), .s_address(b_saddr), .s_wr(b_swr), .s_din(b_sdin));

   bus_rr #(.NUM_M(2), .NUM_S(2), .ADDR_W(8), .DATA_W(32), .REGION_BITS(5), .HOLD_MAX(4)) u_c (
      .clk(clk), .reset(reset), .m_req(c_req), .m_wr(c_wr), .m_address(c_addr),
      .m_dout(c_mdout), .s_dout(c_sdout), .m_grant(c_grant), .m_din(c_din), .m_err(c_err),
      .s_sel(c_sel), .s_address(c_saddr), .s_wr(c_swr), .s_din(c_sdin));

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input string tag, input logic [63:0] val);
      tag_q.push_back(tag);
      val_q.push_back(val);
   endtask

   task automatic check(input string tag, input logic [63:0] obs);
      string       etag;
      logic [63:0] eval;
      n_checks++;
      if (val_q.size() == 0) begin
         n_errors++;
         $error("FAIL %s: observed %0h, scoreboard had no expected value", tag, obs);
      end else begin
         etag = tag_q.pop_front();
         eval = val_q.pop_front();
         assert (obs === eval && etag == tag) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (queued as %s)", tag, obs, eval, etag);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      a_req = '0; a_wr = '0; a_addr = '0; a_mdout = '0; a_sdout = '0;
      b_req = '0; b_wr = '0; b_addr = '0; b_mdout = '0; b_sdout = '0;
      c_req = '0; c_wr = '0; c_addr = '0; c_mdout = '0; c_sdout = '0;
      tick();
      tick();

      push("rst_grant", 64'h1); push("rst_din", 64'h0); push("rst_err", 64'h0);
      push("rst_b_grant", 64'h1); push("rst_c_grant", 64'h1);
      check("rst_grant", a_grant); check("rst_din", a_din); check("rst_err", a_err);
      check("rst_b_grant", b_grant); check("rst_c_grant", c_grant);

      // Single-master write to slave 0, then slave 1
      reset = 1'b0;
      a_req = 2'b01; a_wr = 2'b01; a_addr[7:0] = 8'h01; a_mdout[31:0] = 32'h12345678;
      push("wr_sel", 64'h1); push("wr_swr", 64'h1); push("wr_sdin", 64'h12345678); push("wr_saddr", 64'h01);
      #1;
      check("wr_sel", a_sel); check("wr_swr", a_swr); check("wr_sdin", a_sdin); check("wr_saddr", a_saddr);
      tick();
      push("wr_grant", 64'h1); push("wr_err", 64'h0); push("wr_din", 64'h0);
      check("wr_grant", a_grant); check("wr_err", a_err); check("wr_din", a_din);
      a_addr[7:0] = 8'h21;
      push("wr1_sel", 64'h2); push("wr1_swr", 64'h1);
      #1;
      check("wr1_sel", a_sel); check("wr1_swr", a_swr);
      tick();

      // Handoff to master 1, read from slave 1
      a_req = 2'b10; a_wr = 2'b00; a_addr[15:8] = 8'h21;
      a_sdout = {32'hFFFF1111, 32'hAAAA0000};
      push("ho_idle_sel", 64'h0); push("ho_idle_swr", 64'h0);
      #1;
      check("ho_idle_sel", a_sel); check("ho_idle_swr", a_swr);
      tick();
      push("ho_grant", 64'h2);
      check("ho_grant", a_grant);
      push("ho_sel", 64'h2); push("ho_swr", 64'h0); push("ho_saddr", 64'h21);
      #1;
      check("ho_sel", a_sel); check("ho_swr", a_swr); check("ho_saddr", a_saddr);
      tick();
      push("ho_din", 64'hFFFF1111); push("ho_err", 64'h0);
      check("ho_din", a_din); check("ho_err", a_err);
      a_req = 2'b00;
      push("park_sel", 64'h0);
      #1;
      check("park_sel", a_sel);
      tick();
      push("park_din", 64'h0); push("park_grant", 64'h2);
      check("park_din", a_din); check("park_grant", a_grant);

      // Unlimited hold: master 0 keeps the bus while master 1 waits
      a_req = 2'b01;
      tick();
      a_req = 2'b11;
      for (int i = 0; i < 6; i++) begin
         push("hold0_grant", 64'h1);
         check("hold0_grant", a_grant);
         tick();
      end

      // Decode error and region boundaries
      a_req = 2'b01; a_wr = 2'b01; a_addr[7:0] = 8'h42;
      push("derr_sel", 64'h0); push("derr_swr", 64'h0);
      #1;
      check("derr_sel", a_sel); check("derr_swr", a_swr);
      tick();
      push("derr_err", 64'h1); push("derr_din", 64'h0);
      check("derr_err", a_err); check("derr_din", a_din);
      a_addr[7:0] = 8'h11;
      push("dok_sel", 64'h1); push("dok_swr", 64'h1);
      #1;
      check("dok_sel", a_sel); check("dok_swr", a_swr);
      tick();
      push("dok_err", 64'h0);
      check("dok_err", a_err);
      a_wr = 2'b00; a_addr[7:0] = 8'h3F;
      push("top_sel", 64'h2);
      #1;
      check("top_sel", a_sel);
      tick();
      push("top_din", 64'hFFFF1111); push("top_err", 64'h0);
      check("top_din", a_din); check("top_err", a_err);
      a_addr[7:0] = 8'h40;
      push("rerr_sel", 64'h0);
      #1;
      check("rerr_sel", a_sel);
      tick();
      push("rerr_err", 64'h1); push("rerr_din", 64'h0);
      check("rerr_err", a_err); check("rerr_din", a_din);
      a_req = 2'b00;
      tick();
      push("idle_err", 64'h0);
      check("idle_err", a_err);

      // Reset in the select cycle of a read by master 1
      a_req = 2'b10;
      tick();
      a_wr = 2'b00; a_addr[15:8] = 8'h01;
      push("rmid_sel", 64'h1); push("rmid_saddr", 64'h01);
      #1;
      check("rmid_sel", a_sel); check("rmid_saddr", a_saddr);
      reset = 1'b1;
      tick();
      push("rmid_din", 64'h0); push("rmid_err", 64'h0); push("rmid_grant", 64'h1);
      check("rmid_din", a_din); check("rmid_err", a_err); check("rmid_grant", a_grant);
      reset = 1'b0;
      a_req = 2'b00;

      // Three-master round robin; each master skips one cycle after its access
      b_addr = {8'h05, 8'h21, 8'h00};
      for (int i = 0; i < 9; i++) begin
         b_req = rr_req[i];
         push("rr_grant", 64'(rr_grant[i])); push("rr_sel", 64'(rr_sel[i]));
         #1;
         check("rr_grant", b_grant); check("rr_sel", b_sel);
         tick();
      end
      b_req = 3'b000;

      // Hold limit of 4 cycles, then counter saturation with a lone requester
      c_addr = {8'h21, 8'h01};
      c_req  = 2'b11;
      for (int i = 0; i < 16; i++) begin
         push("burst_grant", (((i / 4) % 2) == 0) ? 64'h1 : 64'h2);
         #1;
         check("burst_grant", c_grant);
         tick();
      end
      c_req = 2'b01;
      for (int i = 0; i < 6; i++) begin
         push("sat_grant", 64'h1);
         #1;
         check("sat_grant", c_grant);
         tick();
      end
      c_req = 2'b11;
      push("sat_hold", 64'h1);
      #1;
      check("sat_hold", c_grant);
      tick();
      push("sat_switch", 64'h2);
      #1;
      check("sat_switch", c_grant);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
